// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: request payload,
// write-port source select and architectural register count.
package rf_arb_pkg;

  localparam int unsigned ADDRESS_WIDTH = 5;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned NUM_REGS      = 32;

  typedef logic [ADDRESS_WIDTH-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t             rd;
    logic [DATA_WIDTH-1:0] wd;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_FIFO
  } wr_src_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// WB / MDU / decode-check / register-file signals of the write arbiter.
// master drives requests and checks; slave is the arbiter.
interface rf_write_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     pipe_we;
  logic [ADDRESS_WIDTH-1:0] pipe_rd;
  logic [DATA_WIDTH-1:0]    pipe_wd;
  logic                     mdu_valid;
  logic [ADDRESS_WIDTH-1:0] mdu_rd;
  logic [DATA_WIDTH-1:0]    mdu_wd;
  logic                     mdu_ready;
  logic                     issue_valid;
  logic [ADDRESS_WIDTH-1:0] issue_rd;
  logic [ADDRESS_WIDTH-1:0] chk_rs1;
  logic [ADDRESS_WIDTH-1:0] chk_rs2;
  logic [ADDRESS_WIDTH-1:0] chk_rd;
  logic                     hazard_stall;
  logic                     pipe_hold;
  logic                     WE3;
  logic [ADDRESS_WIDTH-1:0] AD3;
  logic [DATA_WIDTH-1:0]    WD3;

  modport master (
    output pipe_we, pipe_rd, pipe_wd, mdu_valid, mdu_rd, mdu_wd,
           issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
    input  mdu_ready, hazard_stall, pipe_hold, WE3, AD3, WD3
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_wd, mdu_valid, mdu_rd, mdu_wd,
           issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
    output mdu_ready, hazard_stall, pipe_hold, WE3, AD3, WD3
  );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; head is visible combinationally, contents are not
// reset (only the pointers), so reset simply discards whatever was stored.
module sync_fifo
  import rf_arb_pkg::*;
#(
  parameter type         T     = wb_req_t,
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the reg_file write port between WB and buffered MDU results, forces the
// FIFO head through after repeated denial, and tracks MDU-pending destinations.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input logic               clk,
  input logic               rst,
  rf_write_arbiter_if.slave bus
);
  localparam int unsigned SCW = $clog2(STARVE_LIMIT) + 1;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    wd;
  } req_t;

  req_t                fifo_din;
  req_t                fifo_head;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  wr_src_e             src;
  logic [SCW-1:0]      starve_cnt;
  logic                pipe_hold_q;
  logic                denied;
  logic                starve_hit;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  assign fifo_din      = '{rd: bus.mdu_rd, wd: bus.mdu_wd};
  assign fifo_push     = bus.mdu_valid && !fifo_full && (bus.mdu_rd != '0);
  assign bus.mdu_ready = !fifo_full;

  sync_fifo #(
    .T     (req_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Gated by rst so nothing stale reaches the register file in the reset cycle.
  always_comb begin
    src = SRC_NONE;
    if (!rst) begin
      if (pipe_hold_q && !fifo_empty)             src = SRC_FIFO;
      else if (bus.pipe_we && bus.pipe_rd != '0)  src = SRC_PIPE;
      else if (!fifo_empty)                       src = SRC_FIFO;
    end
  end

  always_comb begin
    bus.WE3 = 1'b0;
    bus.AD3 = '0;
    bus.WD3 = '0;
    case (src)
      SRC_PIPE: begin
        bus.WE3 = 1'b1;
        bus.AD3 = bus.pipe_rd;
        bus.WD3 = bus.pipe_wd;
      end
      SRC_FIFO: begin
        bus.WE3 = 1'b1;
        bus.AD3 = fifo_head.rd;
        bus.WD3 = fifo_head.wd;
      end
      default: ;
    endcase
  end

  assign fifo_pop   = (src == SRC_FIFO);
  assign denied     = !fifo_empty && !fifo_pop;
  assign starve_hit = denied && (starve_cnt == SCW'(STARVE_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt  <= '0;
      pipe_hold_q <= 1'b0;
    end else begin
      pipe_hold_q <= starve_hit;
      if (!denied || starve_hit) starve_cnt <= '0;
      else                       starve_cnt <= starve_cnt + SCW'(1);
    end
  end

  assign bus.pipe_hold = pipe_hold_q;

  // Clear first, then set, so an issue to the register being retired wins.
  always_comb begin
    pending_nxt = pending;
    if (fifo_pop)        pending_nxt[fifo_head.rd] = 1'b0;
    if (bus.issue_valid) pending_nxt[bus.issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  assign bus.hazard_stall = pending[bus.chk_rs1] | pending[bus.chk_rs2] | pending[bus.chk_rd];
endmodule
